// File: rtl/param_mac_accumulator_if.sv
// Operand/result stream bundle for param_mac_accumulator.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface param_mac_accumulator_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20,
  parameter int CW    = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic [CW-1:0]    in_ch;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CW-1:0]    out_ch;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_ch, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_ch, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_ovf
  );
endinterface

// File: rtl/param_mac_accumulator.sv
// Two-stage multi-channel add/multiply accumulator with optional saturation.
// A last beat emits its channel total on a registered output and clears that channel.
module param_mac_accumulator #(
  parameter int WIDTH    = 8,
  parameter int ACC_W    = 20,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  param_mac_accumulator_if.slave bus
);
  localparam int            CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW:0]   CH_LIM = (CW + 1)'(CHANNELS);

  logic                  w_stall;
  logic [WIDTH:0]        w_add;
  logic [2*WIDTH-1:0]    w_mul;
  logic [ACC_W-1:0]      w_term;
  logic                  w_ch_ok;
  logic [ACC_W-1:0]      w_acc_cur;
  logic                  w_ovf_old;
  logic [ACC_W:0]        w_sum;
  logic                  w_ovf_now;
  logic [ACC_W-1:0]      w_value;
  logic                  w_ovf_frame;

  logic                  r_s1_valid;
  logic                  r_s1_last;
  logic [ACC_W-1:0]      r_s1_term;
  logic [CW-1:0]         r_s1_ch;
  logic [ACC_W-1:0]      r_acc [CHANNELS];
  logic [CHANNELS-1:0]   r_ovf;
  logic                  r_out_valid;
  logic                  r_out_ovf;
  logic [ACC_W-1:0]      r_out_data;
  logic [CW-1:0]         r_out_ch;

  // Term formation for stage 1 and the accumulate/saturate arithmetic for stage 2.
  always_comb begin
    w_stall   = r_out_valid && !bus.out_ready;
    w_add     = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    w_mul     = {{WIDTH{1'b0}}, bus.in_a} * {{WIDTH{1'b0}}, bus.in_b};
    w_term    = '0;
    if (bus.in_mode) begin
      w_term[2*WIDTH-1:0] = w_mul;
    end else begin
      w_term[WIDTH:0] = w_add;
    end
    // Out-of-range channels see a zero accumulator and are never written back.
    w_ch_ok   = ({1'b0, r_s1_ch} < CH_LIM);
    w_acc_cur = '0;
    w_ovf_old = 1'b0;
    if (w_ch_ok) begin
      w_acc_cur = r_acc[r_s1_ch];
      w_ovf_old = r_ovf[r_s1_ch];
    end else begin
      w_acc_cur = '0;
      w_ovf_old = 1'b0;
    end
    w_sum     = {1'b0, w_acc_cur} + {1'b0, r_s1_term};
    w_ovf_now = w_sum[ACC_W];
    if ((SATURATE != 0) && w_ovf_now) begin
      w_value = '1;
    end else begin
      w_value = w_sum[ACC_W-1:0];
    end
    w_ovf_frame = w_ovf_old | w_ovf_now;
  end

  // Pipeline registers, accumulators and result register; the whole pipe freezes on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_term   <= '0;
      r_s1_ch     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
      end
      r_ovf       <= '0;
      r_out_valid <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (!w_stall) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_last   <= bus.in_last;
      r_s1_term   <= w_term;
      r_s1_ch     <= bus.in_ch;
      r_out_valid <= 1'b0;
      if (r_s1_valid && w_ch_ok) begin
        if (r_s1_last) begin
          r_out_valid      <= 1'b1;
          r_out_data       <= w_value;
          r_out_ovf        <= w_ovf_frame;
          r_out_ch         <= r_s1_ch;
          r_acc[r_s1_ch]   <= '0;
          r_ovf[r_s1_ch]   <= 1'b0;
        end else begin
          r_acc[r_s1_ch]   <= w_value;
          r_ovf[r_s1_ch]   <= w_ovf_frame;
        end
      end
    end
  end

  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_ovf   = r_out_ovf;
endmodule
